decode_hazard_unit: RTL and testbench

- Parametrised successor to the combinational instruction-class decoder; sits in the D stage of the MIPS pipeline.
- Decodes the D-stage instruction into Tuse/Tnew classes and keeps a scoreboard of in-flight destination registers with Tnew countdown across STAGES downstream stages.
- Tracks the multi-cycle HI/LO unit busy time.
- Produces the D-stage stall and the rs/rt forwarding selects.

---
 rtl/decode_hazard_unit_pkg.sv | 86 ++++++++
 rtl/decode_hazard_unit_if.sv | 32 +++
 rtl/decode_hazard_unit_instr_class_decode.sv | 89 ++++++++
 rtl/decode_hazard_unit.sv | 114 +++++++++++
 tb/tb_decode_hazard_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_hazard_unit_pkg.sv
// Shared decode constants for the D-stage hazard unit.
// Holds the MIPS opcode/funct encodings, the Tuse/Tnew class constants, the
// NO_USE marker for sources an instruction never reads, the return-address
// register index, and the packed decode result consumed by the hazard logic.
package decode_hazard_unit_pkg;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes (ir[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam tuse_t TUSE_0  = 2'd0;
  localparam tuse_t TUSE_1  = 2'd1;
  localparam tuse_t TUSE_2  = 2'd2;
  localparam tuse_t NO_USE  = 2'd3;   // source field is not read

  localparam tnew_t TNEW_0  = 2'd0;
  localparam tnew_t TNEW_1  = 2'd1;
  localparam tnew_t TNEW_2  = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  // Everything the hazard logic needs to know about the D-stage instruction.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;     // 0 means no register write
    tuse_t      tuse_rs;
    tuse_t      tuse_rt;
    tnew_t      tnew;     // cycles until the result exists, counted from stage 1
    logic       md_mul;   // MULT/MULTU: loads MUL_LAT on issue
    logic       md_div;   // DIV/DIVU: loads DIV_LAT on issue
    logic       md_use;   // touches HI/LO, must wait for the unit to go idle
  } dec_t;

endpackage

// File: rtl/decode_hazard_unit_if.sv
// D-stage hazard interface.
// master (pipeline D stage): drives id_valid/id_ir; slave (hazard unit):
// returns stall, fwd_rs_sel, fwd_rt_sel, md_busy and e_dest.
// Handshake: id_valid marks a real instruction in D. When stall is high the
// instruction in D is not accepted: the pipeline holds PC and IF/ID and the
// hazard unit itself puts a bubble into stage 1. An instruction is consumed
// on a clock edge exactly when id_valid=1 and stall=0. stall is never high
// while id_valid=0.
interface decode_hazard_unit_if #(
  parameter int STAGES = 3,
  parameter int REG_W  = 5
) ();
  localparam int SEL_W = $clog2(STAGES + 1);

  logic             id_valid;
  logic [31:0]      id_ir;
  logic             stall;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic             md_busy;
  logic [REG_W-1:0] e_dest;

  modport master (
    output id_valid, id_ir,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy, e_dest
  );

  modport slave (
    input  id_valid, id_ir,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy, e_dest
  );
endinterface

// File: rtl/decode_hazard_unit_instr_class_decode.sv
// instr_class_decode: pure combinational instruction-class decode.
// Ports: ir (D-stage instruction word) -> dec (source/destination indices,
// Tuse for rs and rt, Tnew on entry to stage 1, HI/LO unit flags).
module instr_class_decode
  import decode_hazard_unit_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);
  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       is_nop;

  logic ld, st, cal_r_normal, cal_r_with_sa, cal_r_mul, move_r;
  logic cal_i, lui, b_type, b_zero, jal, jalr, jr;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  // The all-zero word is the canonical nop; treating it as classless keeps
  // it from being seen as an sll that reads rt.
  assign is_nop = (ir == 32'h0);

  always_comb begin
    ld = 1'b0; st = 1'b0; cal_r_normal = 1'b0; cal_r_with_sa = 1'b0;
    cal_r_mul = 1'b0; move_r = 1'b0; cal_i = 1'b0; lui = 1'b0;
    b_type = 1'b0; b_zero = 1'b0; jal = 1'b0; jalr = 1'b0; jr = 1'b0;
    if (!is_nop) begin
      if (op == OP_SPECIAL) begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: cal_r_normal = 1'b1;
          FN_SLL, FN_SRL, FN_SRA:                     cal_r_with_sa = 1'b1;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:         cal_r_mul = 1'b1;
          FN_MFHI, FN_MFLO:                           move_r = 1'b1;
          FN_JR:                                      jr = 1'b1;
          FN_JALR:                                    jalr = 1'b1;
          default: ;
        endcase
      end else begin
        case (op)
          OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:        ld = 1'b1;
          OP_SB, OP_SH, OP_SW:                        st = 1'b1;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI:                   cal_i = 1'b1;
          OP_LUI:                                     lui = 1'b1;
          OP_BEQ, OP_BNE:                             b_type = 1'b1;
          OP_BLEZ, OP_BGTZ, OP_REGIMM:                b_zero = 1'b1;
          OP_JAL:                                     jal = 1'b1;
          // J reads and writes nothing, so it needs no class flag.
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dec.rs = rs;
    dec.rt = rt;

    if (b_type || b_zero || jr || jalr)                       dec.tuse_rs = TUSE_0;
    else if (cal_r_normal || cal_r_mul || cal_i || ld || st)  dec.tuse_rs = TUSE_1;
    else                                                      dec.tuse_rs = NO_USE;

    if (b_type)                                               dec.tuse_rt = TUSE_0;
    else if (cal_r_normal || cal_r_with_sa || cal_r_mul)      dec.tuse_rt = TUSE_1;
    else if (st)                                              dec.tuse_rt = TUSE_2;
    else                                                      dec.tuse_rt = NO_USE;

    if (cal_r_normal || cal_r_with_sa || move_r || jalr)      dec.dest = rd;
    else if (cal_i || lui || ld)                              dec.dest = rt;
    else if (jal)                                             dec.dest = REG_RA;
    else                                                      dec.dest = 5'd0;

    if (ld)                                                   dec.tnew = TNEW_2;
    else if (cal_r_normal || cal_r_with_sa || cal_i || lui || move_r)
                                                              dec.tnew = TNEW_1;
    else                                                      dec.tnew = TNEW_0;

    dec.md_mul = cal_r_mul && (fn == FN_MULT || fn == FN_MULTU);
    dec.md_div = cal_r_mul && (fn == FN_DIV  || fn == FN_DIVU);
    dec.md_use = cal_r_mul || move_r;
  end
endmodule

// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit: D-stage stall and forwarding-select generation.
// Ports: clk, reset (async, active-high); bus (slave modport) carries
// id_valid/id_ir in and stall, fwd_rs_sel, fwd_rt_sel, md_busy, e_dest out.
// Keeps a {dest, tnew} scoreboard for STAGES downstream stages (STAGES >= 2)
// and a HI/LO busy counter. All outputs are combinational from registered
// state plus the D-stage instruction; nothing feeds back from an output.
module decode_hazard_unit
  import decode_hazard_unit_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int REG_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_hazard_unit_if.slave  bus
);
  localparam int SEL_W  = $clog2(STAGES + 1);
  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  dec_t dec;

  instr_class_decode u_decode (
    .ir  (bus.id_ir),
    .dec (dec)
  );

  // Stage k holds the destination of the instruction k stages past D and the
  // cycles remaining until its result exists.
  logic [REG_W-1:0] sb_dest [1:STAGES];
  tnew_t            sb_tnew [1:STAGES];
  logic [CNT_W-1:0] md_cnt;

  logic             md_busy;
  logic             rs_stall, rt_stall, md_stall, stall, issue;
  logic [SEL_W-1:0] rs_sel, rt_sel;

  // Youngest matching stage wins; scanning oldest-first lets later (younger)
  // hits overwrite earlier ones.
  function automatic void check_src(
    input  logic [REG_W-1:0] src,
    input  tuse_t            tuse,
    output logic             src_stall,
    output logic [SEL_W-1:0] src_sel
  );
    logic  hit;
    tnew_t t;
    int    k_win;
    hit       = 1'b0;
    t         = TNEW_0;
    k_win     = 0;
    src_stall = 1'b0;
    src_sel   = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (sb_dest[k] != '0 && sb_dest[k] == src) begin
        hit   = 1'b1;
        t     = sb_tnew[k];
        k_win = k;
      end
    end
    if (hit && tuse != NO_USE) begin
      if (t > tuse)          src_stall = 1'b1;
      else if (t == TNEW_0)  src_sel   = SEL_W'(k_win);
      // otherwise the value is not ready yet but will be picked up by
      // forwarding further down the pipe, so D reads the register file
    end
  endfunction

  assign md_busy = (md_cnt != '0);

  always_comb begin
    check_src(REG_W'(dec.rs), dec.tuse_rs, rs_stall, rs_sel);
    check_src(REG_W'(dec.rt), dec.tuse_rt, rt_stall, rt_sel);
    md_stall = dec.md_use && md_busy;
    stall    = bus.id_valid && (rs_stall || rt_stall || md_stall);
    issue    = bus.id_valid && !stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_dest[k] <= '0;
        sb_tnew[k] <= TNEW_0;
      end
      md_cnt <= '0;
    end else begin
      if (issue) begin
        sb_dest[1] <= REG_W'(dec.dest);
        sb_tnew[1] <= dec.tnew;
      end else begin
        sb_dest[1] <= '0;
        sb_tnew[1] <= TNEW_0;
      end
      for (int k = 2; k <= STAGES; k++) begin
        sb_dest[k] <= sb_dest[k-1];
        sb_tnew[k] <= (sb_tnew[k-1] != TNEW_0) ? sb_tnew[k-1] - TNEW_1 : TNEW_0;
      end

      // An MD op cannot issue while busy (it stalls), so a load never
      // collides with a count in progress.
      if (issue && dec.md_mul)      md_cnt <= CNT_W'(MUL_LAT);
      else if (issue && dec.md_div) md_cnt <= CNT_W'(DIV_LAT);
      else if (md_busy)             md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign bus.stall      = stall;
  assign bus.fwd_rs_sel = rs_sel;
  assign bus.fwd_rt_sel = rt_sel;
  assign bus.md_busy    = md_busy;
  assign bus.e_dest     = sb_dest[1];
endmodule

// File: tb/tb_decode_hazard_unit.sv
// Bench for decode_hazard_unit: directed scenario tasks with constant
// expectations, then a randomized run against an age-based reference model.
module tb_decode_hazard_unit;
  localparam int STAGES  = 3;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int REG_W   = 5;
  localparam int SEL_W   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_hazard_unit_if #(.STAGES(STAGES), .REG_W(REG_W)) bus ();

  decode_hazard_unit #(
    .STAGES(STAGES), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .REG_W(REG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Every accepted instruction is remembered with the cycle it entered
  // stage 1; its stage is its age and its remaining latency is the entry
  // Tnew minus the cycles elapsed since entry.
  typedef struct {
    int dest;
    int tnew0;
    int t_issue;
  } prod_t;

  prod_t hist[$];
  int    cyc = 0;
  int    md_free_at = 0;
  logic [REG_W-1:0] exp_q[$];   // expected e_dest sequence in directed tests

  function automatic void ref_decode(input logic [31:0] ir,
                                     output int dest, output int tnew,
                                     output int use_rs, output int use_rt,
                                     output bit mul, output bit div,
                                     output bit md_use);
    int op, fn, rs, rt, rd;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    dest = 0; tnew = 0; use_rs = -1; use_rt = -1; mul = 0; div = 0; md_use = 0;
    if (op == 0) begin
      case (fn)
        'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b,
        'h04, 'h06, 'h07: begin use_rs = 1; use_rt = 1; dest = rd; tnew = 1; end
        'h00, 'h02, 'h03: begin use_rt = 1; dest = rd; tnew = 1; end
        'h18, 'h19: begin use_rs = 1; use_rt = 1; mul = 1; md_use = 1; end
        'h1a, 'h1b: begin use_rs = 1; use_rt = 1; div = 1; md_use = 1; end
        'h10, 'h12: begin dest = rd; tnew = 1; md_use = 1; end
        'h08: use_rs = 0;
        'h09: begin use_rs = 0; dest = rd; tnew = 0; end
        default: ;
      endcase
    end else begin
      case (op)
        'h20, 'h21, 'h23, 'h24, 'h25: begin use_rs = 1; dest = rt; tnew = 2; end
        'h28, 'h29, 'h2b: begin use_rs = 1; use_rt = 2; end
        'h08, 'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e: begin use_rs = 1; dest = rt; tnew = 1; end
        'h0f: begin dest = rt; tnew = 1; end
        'h04, 'h05: begin use_rs = 0; use_rt = 0; end
        'h06, 'h07, 'h01: use_rs = 0;
        'h03: begin dest = 31; tnew = 0; end
        default: ;
      endcase
    end
  endfunction

  function automatic void ref_src(input int src, input int tuse,
                                  output bit stl, output int sel);
    int best, rem, age;
    best = 0; rem = 0; stl = 0; sel = 0;
    if (tuse < 0 || src == 0) return;
    foreach (hist[i]) begin
      age = cyc - hist[i].t_issue + 1;
      if (age >= 1 && age <= STAGES && hist[i].dest == src &&
          (best == 0 || age < best)) begin
        best = age;
        rem  = hist[i].tnew0 - (age - 1);
        if (rem < 0) rem = 0;
      end
    end
    if (best == 0) return;
    if (rem > tuse) stl = 1;
    else if (rem == 0) sel = best;
  endfunction

  function automatic void model_expect(input logic v, input logic [31:0] ir,
                                       output bit st, output int sel_rs,
                                       output int sel_rt, output bit busy,
                                       output int ed);
    int dest, tnew, urs, urt;
    bit mul, div, mdu, s_rs, s_rt;
    ref_decode(ir, dest, tnew, urs, urt, mul, div, mdu);
    busy = (cyc < md_free_at);
    ed = 0;
    foreach (hist[i]) if (hist[i].t_issue == cyc) ed = hist[i].dest;
    ref_src(int'(ir[25:21]), urs, s_rs, sel_rs);
    ref_src(int'(ir[20:16]), urt, s_rt, sel_rt);
    st = v && (s_rs || s_rt || (mdu && busy));
  endfunction

  function automatic void model_clear();
    hist.delete();
    md_free_at = 0;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs,
                                        input int rt, input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs,
                                        input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ir);
    bus.id_valid = v;
    bus.id_ir    = ir;
    #1;
  endtask

  // Advance one clock; the model accepts the instruction on its own verdict.
  task automatic tick();
    bit st, busy; int srs, srt, ed;
    int dest, tnew, urs, urt; bit mul, div, mdu;
    logic v; logic [31:0] ir;
    v = bus.id_valid; ir = bus.id_ir;
    model_expect(v, ir, st, srs, srt, busy, ed);
    ref_decode(ir, dest, tnew, urs, urt, mul, div, mdu);
    @(posedge clk);
    cyc++;
    if (v && !st) begin
      hist.push_front('{dest: dest, tnew0: tnew, t_issue: cyc});
      if (mul) md_free_at = cyc + MUL_LAT;
      if (div) md_free_at = cyc + DIV_LAT;
    end
    while (hist.size() > 0 && cyc - hist[$].t_issue + 1 > STAGES) void'(hist.pop_back());
    #1;
  endtask

  task automatic reset_dut();
    bus.id_valid = 1'b0;
    bus.id_ir    = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    drive(1'b0, 32'h0);
    n_vec++; if (bus.stall !== 1'b0)       begin n_err++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
    n_vec++; if (bus.fwd_rs_sel !== 2'd0)  begin n_err++; $display("FAIL reset_fwd_rs: got %0d want 0", bus.fwd_rs_sel); end
    n_vec++; if (bus.fwd_rt_sel !== 2'd0)  begin n_err++; $display("FAIL reset_fwd_rt: got %0d want 0", bus.fwd_rt_sel); end
    n_vec++; if (bus.md_busy !== 1'b0)     begin n_err++; $display("FAIL reset_md_busy: got %0b want 0", bus.md_busy); end
    n_vec++; if (bus.e_dest !== 5'd0)      begin n_err++; $display("FAIL reset_e_dest: got %0d want 0", bus.e_dest); end
    drive(1'b1, enc_r(6'h21, 8, 11, 10, 0));
    n_vec++; if (bus.stall !== 1'b0)       begin n_err++; $display("FAIL reset_empty_sb_stall: got %0b want 0", bus.stall); end
  endtask

  task automatic test_load_use();
    logic [31:0] lw8, addu;
    lw8  = enc_i(6'h23, 9, 8, 0);
    addu = enc_r(6'h21, 8, 11, 10, 0);
    reset_dut();
    exp_q = '{5'd8, 5'd0, 5'd10};
    drive(1'b1, lw8); tick();
    // An invalid slot never stalls, even with a matching producer.
    drive(1'b0, addu);
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL invalid_no_stall: got %0b want 0", bus.stall); end
    drive(1'b1, addu);
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %0b want 1", bus.stall); end
    n_vec++; if (bus.e_dest !== exp_q[0]) begin n_err++; $display("FAIL load_use_e_dest_lw: got %0d want %0d", bus.e_dest, exp_q[0]); end
    tick();
    // lw now sits in stage 2 with one cycle still to go, which the addu
    // can absorb (Tuse 1): no stall and no D-stage forward.
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %0b want 0", bus.stall); end
    n_vec++; if (bus.fwd_rs_sel !== 2'd0) begin n_err++; $display("FAIL load_use_fwd_rs: got %0d want 0", bus.fwd_rs_sel); end
    n_vec++; if (bus.e_dest !== exp_q[1]) begin n_err++; $display("FAIL load_use_bubble: got %0d want %0d", bus.e_dest, exp_q[1]); end
    tick();
    n_vec++; if (bus.e_dest !== exp_q[2]) begin n_err++; $display("FAIL load_use_e_dest_addu: got %0d want %0d", bus.e_dest, exp_q[2]); end
  endtask

  task automatic test_branch();
    logic [31:0] beq;
    beq = enc_i(6'h04, 3, 0, 16);
    reset_dut();
    drive(1'b1, enc_r(6'h21, 1, 2, 3, 0)); tick();
    drive(1'b1, beq);
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL branch_stall: got %0b want 1", bus.stall); end
    tick();
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL branch_release: got %0b want 0", bus.stall); end
    n_vec++; if (bus.fwd_rs_sel !== 2'd2) begin n_err++; $display("FAIL branch_fwd_rs: got %0d want 2", bus.fwd_rs_sel); end
    n_vec++; if (bus.fwd_rt_sel !== 2'd0) begin n_err++; $display("FAIL branch_fwd_rt: got %0d want 0", bus.fwd_rt_sel); end
    tick();
  endtask

  task automatic test_store();
    reset_dut();
    drive(1'b1, enc_i(6'h23, 7, 5, 0)); tick();
    drive(1'b1, enc_i(6'h2b, 6, 5, 4));
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL store_stall: got %0b want 0", bus.stall); end
    n_vec++; if (bus.fwd_rt_sel !== 2'd0) begin n_err++; $display("FAIL store_fwd_rt: got %0d want 0", bus.fwd_rt_sel); end
    n_vec++; if (bus.fwd_rs_sel !== 2'd0) begin n_err++; $display("FAIL store_fwd_rs: got %0d want 0", bus.fwd_rs_sel); end
    tick();
  endtask

  task automatic test_jal_zero();
    logic [31:0] use31;
    logic [1:0]  want;
    use31 = enc_r(6'h21, 31, 0, 4, 0);
    reset_dut();
    drive(1'b1, {6'h03, 26'h0000100}); tick();
    // Follow the JAL result through every stage and past the last one.
    for (int k = 1; k <= STAGES + 1; k++) begin
      want = (k <= STAGES) ? 2'(k) : 2'd0;
      drive(1'b1, use31);
      n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL jal_stall_k%0d: got %0b want 0", k, bus.stall); end
      n_vec++; if (bus.fwd_rs_sel !== want) begin n_err++; $display("FAIL jal_fwd_rs_k%0d: got %0d want %0d", k, bus.fwd_rs_sel, want); end
      drive(1'b0, use31); tick();
    end
    drive(1'b1, enc_r(6'h21, 1, 2, 0, 0)); tick();
    n_vec++; if (bus.e_dest !== 5'd0) begin n_err++; $display("FAIL zero_dest: got %0d want 0", bus.e_dest); end
    drive(1'b1, enc_r(6'h21, 0, 0, 5, 0));
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL zero_src_stall: got %0b want 0", bus.stall); end
    n_vec++; if (bus.fwd_rs_sel !== 2'd0) begin n_err++; $display("FAIL zero_src_fwd_rs: got %0d want 0", bus.fwd_rs_sel); end
    n_vec++; if (bus.fwd_rt_sel !== 2'd0) begin n_err++; $display("FAIL zero_src_fwd_rt: got %0d want 0", bus.fwd_rt_sel); end
    tick();
  endtask

  task automatic test_md();
    logic [31:0] issue_ir [2];
    logic [31:0] read_ir  [2];
    int lat [2];
    int n;
    issue_ir[0] = enc_r(6'h1a, 1, 2, 0, 0); read_ir[0] = enc_r(6'h12, 0, 0, 3, 0); lat[0] = DIV_LAT;
    issue_ir[1] = enc_r(6'h18, 1, 2, 0, 0); read_ir[1] = enc_r(6'h10, 0, 0, 4, 0); lat[1] = MUL_LAT;
    for (int t = 0; t < 2; t++) begin
      reset_dut();
      drive(1'b1, issue_ir[t]); tick();
      drive(1'b1, read_ir[t]);
      n = 0;
      while (bus.stall === 1'b1 && n < 20) begin
        n_vec++; if (bus.md_busy !== 1'b1) begin n_err++; $display("FAIL md_busy_t%0d_c%0d: got %0b want 1", t, n, bus.md_busy); end
        n++;
        tick();
        drive(1'b1, read_ir[t]);
      end
      n_vec++; if (n !== lat[t]) begin n_err++; $display("FAIL md_stall_cycles_t%0d: got %0d want %0d", t, n, lat[t]); end
      n_vec++; if (bus.md_busy !== 1'b0) begin n_err++; $display("FAIL md_idle_t%0d: got %0b want 0", t, bus.md_busy); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] addu;
    addu = enc_r(6'h21, 8, 11, 10, 0);
    reset_dut();
    drive(1'b1, enc_r(6'h1a, 1, 2, 0, 0)); tick();
    drive(1'b1, enc_i(6'h23, 9, 8, 0)); tick();
    drive(1'b1, addu);
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: got %0b want 1", bus.stall); end
    reset = 1'b1;
    #1;
    n_vec++; if (bus.stall !== 1'b0)   begin n_err++; $display("FAIL mid_reset_stall: got %0b want 0", bus.stall); end
    n_vec++; if (bus.md_busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_md_busy: got %0b want 0", bus.md_busy); end
    n_vec++; if (bus.e_dest !== 5'd0)  begin n_err++; $display("FAIL mid_reset_e_dest: got %0d want 0", bus.e_dest); end
    #4;
    reset = 1'b0;
    model_clear();
    drive(1'b1, addu);
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mid_after_stall: got %0b want 0", bus.stall); end
    tick();
  endtask

  function automatic int rnd_reg();
    int r;
    r = int'($urandom_range(0, 6));
    return (r == 6) ? 31 : r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    int p, k;
    p = int'($urandom_range(0, 99));
    if (p < 3) return enc_r(($urandom_range(0, 1) != 0) ? 6'h18 : 6'h1a, rnd_reg(), rnd_reg(), 0, 0);
    if (p < 9) return enc_r(($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12, 0, 0, rnd_reg(), 0);
    k = int'($urandom_range(0, 11));
    case (k)
      0:  return enc_r(6'h21, rnd_reg(), rnd_reg(), rnd_reg(), 0);
      1:  return enc_r(6'h00, 0, rnd_reg(), rnd_reg(), int'($urandom_range(0, 31)));
      2:  return enc_r(6'h08, rnd_reg(), 0, 0, 0);
      3:  return enc_r(6'h09, rnd_reg(), 0, rnd_reg(), 0);
      4:  return enc_i(6'h23, rnd_reg(), rnd_reg(), 4);
      5:  return enc_i(6'h2b, rnd_reg(), rnd_reg(), 8);
      6:  return enc_i(6'h09, rnd_reg(), rnd_reg(), 1);
      7:  return enc_i(6'h0f, 0, rnd_reg(), 16'h1234);
      8:  return enc_i(6'h04, rnd_reg(), rnd_reg(), 2);
      9:  return enc_i(6'h06, rnd_reg(), 0, 2);
      10: return {6'h03, 26'($urandom)};
      default: return enc_r(6'h2a, rnd_reg(), rnd_reg(), rnd_reg(), 0);
    endcase
  endfunction

  task automatic test_random();
    logic v; logic [31:0] ir;
    bit st, busy; int srs, srt, ed;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      ir = rnd_instr();
      drive(v, ir);
      model_expect(v, ir, st, srs, srt, busy, ed);
      n_vec++; if (bus.stall !== st) begin n_err++; $display("FAIL rnd_stall_%0d ir=%08h: got %0b want %0b", i, ir, bus.stall, st); end
      n_vec++; if (bus.md_busy !== busy) begin n_err++; $display("FAIL rnd_md_busy_%0d: got %0b want %0b", i, bus.md_busy, busy); end
      n_vec++; if (bus.e_dest !== 5'(ed)) begin n_err++; $display("FAIL rnd_e_dest_%0d: got %0d want %0d", i, bus.e_dest, ed); end
      if (!st) begin
        n_vec++; if (bus.fwd_rs_sel !== SEL_W'(srs)) begin n_err++; $display("FAIL rnd_fwd_rs_%0d ir=%08h: got %0d want %0d", i, ir, bus.fwd_rs_sel, srs); end
        n_vec++; if (bus.fwd_rt_sel !== SEL_W'(srt)) begin n_err++; $display("FAIL rnd_fwd_rt_%0d ir=%08h: got %0d want %0d", i, ir, bus.fwd_rt_sel, srt); end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_ir = 32'h0;
    test_reset();
    test_load_use();
    test_branch();
    test_store();
    test_jal_zero();
    test_md();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
